// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and clear-FSM state type
// for the CPU31 multi-port register file.
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int ZERO_REG  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential clear sweep over registers
// 1..DEPTH-1, one register per enabled cycle.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          RF_clk,
  input  logic          RF_rst,
  input  logic          RF_ena,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_stb,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST = AW'(1);

  clr_state_e    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_stb   = 1'b0;
    clr_addr  = ptr;
    unique case (state)
      IDLE: begin
        if (clr_req && RF_ena) begin
          state_nxt = SWEEP;
          ptr_nxt   = FIRST;
        end
      end
      SWEEP: begin
        if (RF_ena) begin
          clr_stb = 1'b1;
          ptr_nxt = ptr + FIRST;
          if (ptr == LAST) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == SWEEP);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 2-write register file with bypass,
// busy scoreboard and a non-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH),
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic            RF_clk,
  input  logic            RF_rst,
  input  logic            RF_ena,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]  rd_busy,
  input  logic            RF_W0,
  input  logic [AW-1:0]   Rdc0,
  input  logic [DW-1:0]   Rd0,
  input  logic            RF_W1,
  input  logic [AW-1:0]   Rdc1,
  input  logic [DW-1:0]   Rd1,
  input  logic            iss_vld,
  input  logic [AW-1:0]   iss_addr,
  input  logic            clr_req,
  output logic            clr_busy
);

  localparam logic [AW-1:0] RZ = AW'(ZERO_REG);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic             we0, we1, iss_ok;
  logic             clr_stb;
  logic [AW-1:0]    clr_addr;

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .RF_clk   (RF_clk),
    .RF_rst   (RF_rst),
    .RF_ena   (RF_ena),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_stb  (clr_stb),
    .clr_addr (clr_addr)
  );

  assign we0 = RF_W0 && RF_ena && (Rdc0 != RZ) && !clr_busy;
  assign we1 = RF_W1 && RF_ena && (Rdc1 != RZ) && !clr_busy;
  assign iss_ok = iss_vld && RF_ena && (iss_addr != RZ)
                  && !clr_busy;

  // port 1 is written last so it wins an address conflict
  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      regs <= '{default: '0};
    end else begin
      if (clr_stb) regs[clr_addr] <= '0;
      if (we0)     regs[Rdc0]     <= Rd0;
      if (we1)     regs[Rdc1]     <= Rd1;
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (clr_stb) busy_nxt[clr_addr] = 1'b0;
    if (we0)     busy_nxt[Rdc0]     = 1'b0;
    if (we1)     busy_nxt[Rdc1]     = 1'b0;
    if (iss_ok)  busy_nxt[iss_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp0, byp1;
    assign ra   = rd_addr[i*AW +: AW];
    assign byp1 = (BYPASS != 0) && we1 && (Rdc1 == ra);
    assign byp0 = (BYPASS != 0) && we0 && (Rdc0 == ra);
    assign rd_data[i*DW +: DW] =
      (!RF_ena || ra == RZ) ? '0  :
      byp1                  ? Rd1 :
      byp0                  ? Rd0 :
                              regs[ra];
    assign rd_busy[i] = RF_ena && busy[ra];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: random + directed checks of regfile_mp
// (bypass and no-bypass copies) against an array model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic              RF_clk = 1'b0;
  logic              RF_rst = 1'b0;
  logic              RF_ena = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]    rd_busy, rd_busy_nb;
  logic              RF_W0 = 1'b0, RF_W1 = 1'b0;
  logic [AW-1:0]     Rdc0 = '0, Rdc1 = '0;
  logic [DW-1:0]     Rd0 = '0, Rd1 = '0;
  logic              iss_vld = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic              clr_req = 1'b0;
  logic              clr_busy, clr_busy_nb;

  int n_chk = 0;
  int n_pass = 0;

  // reference state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  int            m_sweep;

  always #5 RF_clk = ~RF_clk;

  regfile_mp #(.BYPASS(1)) dut (
    .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy),
    .RF_W0(RF_W0), .Rdc0(Rdc0), .Rd0(Rd0),
    .RF_W1(RF_W1), .Rdc1(Rdc1), .Rd1(Rd1),
    .iss_vld(iss_vld), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena),
    .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb),
    .RF_W0(RF_W0), .Rdc0(Rdc0), .Rd0(Rd0),
    .RF_W1(RF_W1), .Rdc1(Rdc1), .Rd1(Rd1),
    .iss_vld(iss_vld), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_nb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
  endtask

  function automatic logic [AW-1:0] ra(input int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic bit w_ok(input bit w,
                              input logic [AW-1:0] a);
    return w && RF_ena && a != 0 && m_sweep == 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(
      input logic [AW-1:0] a, input bit byp);
    if (!RF_ena || a == 0) return '0;
    if (byp && w_ok(RF_W1, Rdc1) && Rdc1 == a) return Rd1;
    if (byp && w_ok(RF_W0, Rdc0) && Rdc0 == a) return Rd0;
    return m_mem[a];
  endfunction

  task automatic check_all();
    for (int p = 0; p < NRD; p++) begin
      chk("rd_byp", rd_data[p*DW +: DW], exp_rd(ra(p), 1));
      chk("rd_nb", rd_data_nb[p*DW +: DW], exp_rd(ra(p), 0));
      chk("rd_busy", 32'(rd_busy[p]),
          32'(RF_ena && m_busy[ra(p)]));
    end
    chk("clr_busy", 32'(clr_busy), 32'(m_sweep != 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 0;
    end
    m_sweep = 0;
  endtask

  task automatic model_edge();
    bit v0, v1, sw;
    if (!RF_ena) return;
    v0 = w_ok(RF_W0, Rdc0);
    v1 = w_ok(RF_W1, Rdc1);
    sw = (m_sweep != 0);
    if (sw) begin
      m_mem[m_sweep] = '0;
      m_busy[m_sweep] = 0;
      m_sweep = (m_sweep == DEPTH - 1) ? 0 : m_sweep + 1;
    end else if (clr_req) begin
      m_sweep = 1;
    end
    if (v0) begin m_mem[Rdc0] = Rd0; m_busy[Rdc0] = 0; end
    if (v1) begin m_mem[Rdc1] = Rd1; m_busy[Rdc1] = 0; end
    if (iss_vld && !sw && iss_addr != 0)
      m_busy[iss_addr] = 1;
  endtask

  task automatic quiet();
    RF_W0 = 0; RF_W1 = 0; iss_vld = 0; clr_req = 0;
    RF_ena = 1;
  endtask

  task automatic rand_in(input bit allow_clr);
    RF_W0 = 1'($urandom);
    RF_W1 = 1'($urandom);
    Rdc0 = AW'($urandom);
    Rdc1 = ($urandom_range(0, 3) == 0) ? Rdc0 : AW'($urandom);
    Rd0 = $urandom;
    Rd1 = $urandom;
    iss_vld = ($urandom_range(0, 3) == 0);
    iss_addr = ($urandom_range(0, 2) == 0) ? Rdc0 : AW'($urandom);
    clr_req = allow_clr && ($urandom_range(0, 60) == 0);
    RF_ena = ($urandom_range(0, 9) != 0);
    rd_addr = {AW'($urandom), ($urandom_range(0, 1) == 0)
               ? Rdc1 : AW'($urandom)};
  endtask

  // inputs are driven just after negedge; check then edge
  task automatic tick();
    #1 check_all();
    @(posedge RF_clk);
    model_edge();
    @(negedge RF_clk);
  endtask

  task automatic async_reset();
    #2 RF_rst = 1;
    #1;
    model_reset();
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_clr", 32'(clr_busy), 32'h0);
    @(negedge RF_clk);
    RF_rst = 0;
  endtask

  task automatic wr0(input int a, input logic [31:0] d);
    quiet();
    RF_W0 = 1; Rdc0 = AW'(a); Rd0 = d;
    tick();
  endtask

  // counts cycles with clr_busy high; stall_at >= 0 drops
  // RF_ena for 3 cycles at that point of the sweep
  task automatic sweep_len(input int stall_at,
                           output int n);
    int k;
    n = 0; k = 0;
    while (clr_busy && n < 100) begin
      rand_in(0);
      RF_ena = !(stall_at >= 0 && k >= stall_at
                 && k < stall_at + 3);
      clr_req = (k == 10);
      tick();
      n++; k++;
    end
  endtask

  initial begin
    int n;
    model_reset();
    quiet();
    RF_rst = 1;
    #12 RF_rst = 0;
    @(negedge RF_clk);
    tick();

    // fill some state, then reset asynchronously mid-cycle
    for (int i = 1; i < 8; i++) begin
      wr0(i, $urandom);
      iss_vld = 1; iss_addr = AW'(i + 8); tick();
    end
    quiet();
    rd_addr = {AW'(3), AW'(9)};
    async_reset();

    wr0(5, 32'hDEADBEEF);
    quiet(); rd_addr = {AW'(0), AW'(5)};
    #1 chk("r5", rd_data[31:0], 32'hDEADBEEF);
    tick();

    // r0 protection
    quiet();
    RF_W0 = 1; RF_W1 = 1; Rdc0 = 0; Rdc1 = 0;
    Rd0 = 32'h12345678; Rd1 = 32'h12345678;
    iss_vld = 1; iss_addr = 0; rd_addr = '0;
    tick();
    quiet();
    #1 chk("r0", rd_data[31:0], 32'h0);
    chk("r0_busy", 32'(rd_busy[0]), 32'h0);
    tick();

    // port conflict and bypass
    wr0(7, 32'h1111);
    quiet();
    RF_W0 = 1; RF_W1 = 1; Rdc0 = 7; Rdc1 = 7;
    Rd0 = 32'hAAAA; Rd1 = 32'h5555;
    rd_addr = {AW'(7), AW'(7)};
    #1 chk("byp_conf", rd_data[31:0], 32'h5555);
    chk("nb_conf", rd_data_nb[31:0], 32'h1111);
    tick();
    quiet();
    #1 chk("st_conf", rd_data_nb[63:32], 32'h5555);
    tick();

    // scoreboard
    quiet(); iss_vld = 1; iss_addr = 9;
    rd_addr = {AW'(9), AW'(9)};
    tick();
    quiet();
    #1 chk("sb_set", 32'(rd_busy[0]), 32'h1);
    RF_W0 = 1; Rdc0 = 9; Rd0 = 32'h99;
    iss_vld = 1; iss_addr = 9;
    tick();
    quiet();
    #1 chk("sb_win", 32'(rd_busy[0]), 32'h1);
    RF_W1 = 1; Rdc1 = 9; Rd1 = 32'h98;
    tick();
    quiet();
    #1 chk("sb_clr", 32'(rd_busy[1]), 32'h0);
    tick();

    // full sweep
    for (int i = 1; i < DEPTH; i++) wr0(i, 32'(i) * 32'h01010101);
    quiet(); clr_req = 1; tick();
    sweep_len(-1, n);
    chk("sweep_len", 32'(n), 32'd31);
    quiet();
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_addr = {AW'(i + 1), AW'(i)};
      #1 chk("zero_lo", rd_data[31:0], 32'h0);
      chk("zero_hi", rd_data[63:32], 32'h0);
      tick();
    end

    // enable stall mid-sweep
    for (int i = 1; i < DEPTH; i += 3) wr0(i, $urandom);
    quiet(); clr_req = 1; tick();
    sweep_len(12, n);
    chk("stall_len", 32'(n), 32'd34);

    // reset mid-sweep
    quiet(); clr_req = 1; tick();
    for (int i = 0; i < 6; i++) begin
      rand_in(0); RF_ena = 1; tick();
    end
    quiet();
    async_reset();
    tick();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rand_in(1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=done", n_chk);
    $fatal(1);
  end

endmodule
